ysyx_axi4_sram_slave: RTL and testbench
=======================================

# ysyx_axi4_sram_slave

AXI4 responder (slave) backing an on-chip memory array. It answers the core's AXI4 master port (the `io_master_*` bundle): single-beat and INCR/FIXED bursts on independent read and write channels, with byte strobes and an optional LFSR-driven response delay. It is the simulation/FPGA memory endpoint in place of the external SoC fabric.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 64, data bus width (fixed 64; 8 byte lanes)
- `ID_W`, 4, AXI ID width
- `MEM_WORDS`, 4096, number of 64-bit words in the array
- `BASE_ADDR`, 32'h8000_0000, first byte address mapped to word 0
- `RAND_DELAY`, 1, 1 = insert 0–3 cycle LFSR delay before first R beat and before B; 0 = no delay

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `arid/araddr/arlen/arsize/arburst`  in  ID_W/ADDR_W/8/3/2  read address
- `arvalid` in 1, `arready` out 1
- `rid` out ID_W, `rdata` out 64, `rresp` out 2, `rlast` out 1, `rvalid` out 1, `rready` in 1
- `awid/awaddr/awlen/awsize/awburst`  in  ID_W/ADDR_W/8/3/2  write address
- `awvalid` in 1, `awready` out 1
- `wdata` in 64, `wstrb` in 8, `wlast` in 1, `wvalid` in 1, `wready` out 1
- `bid` out ID_W, `bresp` out 2, `bvalid` out 1, `bready` in 1

## Operation
- Read and write channels are independent FSMs; they may run concurrently.
- Read FSM: R_IDLE → (R_WAIT if delay>0) → R_DATA → R_IDLE.
  - R_IDLE: `arready`=1. On `arvalid&arready` latch id, addr, len, size, burst; beat counter := 0.
  - R_WAIT: count down LFSR[1:0] cycles.
  - R_DATA: `rvalid`=1, `rdata` = mem[(addr−BASE_ADDR)>>3], full 64-bit word (master selects lane). `rlast`=1 when counter==len. On `rvalid&rready`: counter+1; INCR: addr += 1<<size; FIXED: addr unchanged. After last beat → R_IDLE.
- Write FSM: W_IDLE → W_DATA → (W_WAIT) → W_RESP → W_IDLE.
  - W_IDLE: `awready`=1; latch AW fields on handshake.
  - W_DATA: `wready`=1. Each `wvalid&wready` writes bytes i where `wstrb[i]`=1; advance addr as for reads. Leave on beat with `wlast`=1.
  - W_RESP: `bvalid`=1, `bid`=latched id; on `bready` → W_IDLE.
- Response codes: OKAY (2'b00) normally. SLVERR (2'b10) when: address outside [BASE_ADDR, BASE_ADDR+8·MEM_WORDS); `*burst`=2'b10 (WRAP) or 2'b11; write beat count with `wlast` ≠ awlen+1. Out-of-range reads return `rdata`=0; out-of-range/erroneous write beats are not committed. Read rresp is per beat; bresp is sticky over the burst.
- Arithmetic: address increments wrap modulo 2^ADDR_W; word index uses bits [ADDR_W-1:3] of (addr−BASE_ADDR).
- LFSR: 20-bit, seed 1, taps [19]^[18], advances every cycle; sampled at AR/AW handshake.

## Timing
- Reset (async assert): `arready`=0, `awready`=0, `wready`=0, `rvalid`=0, `bvalid`=0, `rlast`=0, `rdata`=0, `rresp`=0, `rid`=0, `bresp`=0, `bid`=0; FSMs idle, LFSR:=1. Memory contents retained. Ready outputs rise the first cycle after deassertion. Reset mid-burst aborts without a response.
- Read latency (RAND_DELAY=0): AR handshake cycle N → first `rvalid` at N+1; back-to-back beats each cycle while `rready`=1. `arready` low from N+1 until the cycle after the last R handshake.
- Write: AW handshake N → `wready` at N+1; last W handshake M → `bvalid` at M+1 (+delay). `awready` low until cycle after B handshake.
- `rvalid`/`bvalid` and associated payload held stable until handshake.
- Same-cycle read beat and write to same word: read returns the old data.

## Test plan
- Single read: preload mem[0]=64'h1122_3344_5566_7788, AR addr 0x8000_0000 len 0 size 3, RAND_DELAY=0 → `rvalid` next cycle, rdata=that value, rlast=1, rresp=0.
- INCR write burst: AW 0x8000_0010 len 3 size 3, four beats wstrb 8'hFF → bresp=0 one cycle after 4th beat; read-back burst returns same four words in order.
- Strobe/narrow: word 0x8000_0000 = 0; write wdata 64'hAABB_CCDD_0000_0000, wstrb 8'hF0 → read returns 64'hAABB_CCDD_0000_0000.
- Errors: read 0x0000_1000 → rresp=2'b10, rdata=0; write with wlast on beat 2 of awlen=3 → bresp=2'b10, memory unchanged for out-of-range; WRAP burst → SLVERR.
- Backpressure: hold `rready`=0 for 5 cycles mid-burst → rdata/rlast stable; hold `bready`=0 → bvalid stays 1, awready stays 0.
- Reset mid-read burst (beat 1 of 4) → rvalid=0 immediately; after release arready=1 and a new read completes normally; preloaded data intact.

Source files
------------

// File: rtl/ysyx_axi4_sram_slave.sv
// AXI4 slave backed by an on-chip word array: independent read/write FSMs,
// INCR/FIXED bursts, byte strobes, SLVERR on bad address/burst/beat count.
module ysyx_axi4_sram_slave #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       ID_W       = 4,
  parameter int unsigned       MEM_WORDS  = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter bit                RAND_DELAY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int unsigned       IDX_W     = $clog2(MEM_WORDS);
  localparam int unsigned       STRB_W    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS * 8);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a - BASE_ADDR) < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + (ADDR_W'(1) << size);
  endfunction

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [19:0]       lfsr;
  logic [1:0]        delay_pick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 20'd1;
    else      lfsr <= {lfsr[18:0], lfsr[19] ^ lfsr[18]};
  end

  assign delay_pick = RAND_DELAY ? lfsr[1:0] : 2'd0;

  // ---------------- read channel ----------------
  r_state_t          r_state;
  logic [ADDR_W-1:0] r_addr, rd_addr;
  logic [7:0]        r_len, rd_len, r_cnt, rd_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst, rd_burst, r_wait;
  logic              rd_bad, r_load;

  // Address/count of the beat about to be presented: the AR request itself,
  // the latched one after a delay, or the successor of the current beat.
  always_comb begin
    rd_addr  = r_addr;
    rd_burst = r_burst;
    rd_len   = r_len;
    rd_cnt   = r_cnt;
    if (r_state == R_IDLE) begin
      rd_addr  = araddr;
      rd_burst = arburst;
      rd_len   = arlen;
      rd_cnt   = '0;
    end else if (r_state == R_DATA) begin
      rd_addr = next_addr(r_addr, r_size, r_burst);
      rd_cnt  = r_cnt + 8'd1;
    end
    rd_bad = !in_range(rd_addr) || rd_burst[1];
    r_load = ((r_state == R_IDLE) && arvalid && arready && (delay_pick == 2'd0)) ||
             ((r_state == R_WAIT) && (r_wait == 2'd1)) ||
             ((r_state == R_DATA) && rvalid && rready && !rlast);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
      rid     <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            rid     <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_cnt   <= '0;
            r_wait  <= delay_pick;
            r_state <= (delay_pick == 2'd0) ? R_DATA : R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_wait == 2'd1) r_state <= R_DATA;
          else                r_wait  <= r_wait - 2'd1;
        end
        R_DATA: begin
          if (rvalid && rready && rlast) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
      if (r_load) begin
        rvalid <= 1'b1;
        rdata  <= rd_bad ? '0 : mem[word_idx(rd_addr)];
        rresp  <= rd_bad ? 2'b10 : 2'b00;
        rlast  <= (rd_cnt == rd_len);
        r_addr <= rd_addr;
        r_cnt  <= rd_cnt;
      end
    end
  end

  // ---------------- write channel ----------------
  w_state_t          w_state;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [8:0]        w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst, w_wait;
  logic              w_err, w_err_n, w_beat, mem_we;

  always_comb begin
    w_beat  = (w_state == W_DATA) && wvalid && wready;
    mem_we  = w_beat && in_range(w_addr) && !w_burst[1] && (w_cnt <= {1'b0, w_len});
    w_err_n = w_err || !in_range(w_addr) || w_burst[1] ||
              (wlast != (w_cnt == {1'b0, w_len}));
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= '0;
      bid     <= '0;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_wait  <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            w_wait  <= delay_pick;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_addr <= next_addr(w_addr, w_size, w_burst);
            w_cnt  <= w_cnt + 9'd1;
            w_err  <= w_err_n;
            if (wlast) begin
              wready <= 1'b0;
              if (w_wait == 2'd0) begin
                bvalid  <= 1'b1;
                bresp   <= w_err_n ? 2'b10 : 2'b00;
                bid     <= w_id;
                w_state <= W_RESP;
              end else begin
                w_state <= W_WAIT;
              end
            end
          end
        end
        W_WAIT: begin
          if (w_wait == 2'd1) begin
            bvalid  <= 1'b1;
            bresp   <= w_err ? 2'b10 : 2'b00;
            bid     <= w_id;
            w_state <= W_RESP;
          end else begin
            w_wait <= w_wait - 2'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_axi4_sram_slave.sv
// Directed bench for ysyx_axi4_sram_slave with response delay disabled:
// single-beat vector table plus burst, backpressure and reset sequences.
module tb_ysyx_axi4_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  arid = '0, rid, awid = '0, bid;
  logic [31:0] araddr = '0, awaddr = '0;
  logic [7:0]  arlen = '0, awlen = '0, wstrb = '0;
  logic [2:0]  arsize = 3'd3, awsize = 3'd3;
  logic [1:0]  arburst = 2'b01, awburst = 2'b01, rresp, bresp;
  logic        arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b1;
  logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic        bvalid, bready = 1'b1;
  logic [63:0] rdata, wdata = '0;

  always #5 clk = ~clk;

  ysyx_axi4_sram_slave #(
    .ADDR_W(32), .DATA_W(64), .ID_W(4), .MEM_WORDS(4096),
    .BASE_ADDR(32'h8000_0000), .RAND_DELAY(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] wr_data [4];
  logic [7:0]  wr_strb [4];
  logic [63:0] rd_data [4];
  logic [1:0]  rd_resp [4];
  logic        rd_last [4];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
    string       name;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] id,
                            input int stall_beat, input int stall_n,
                            input logic [63:0] stall_data, input logic stall_last);
    araddr = addr; arlen = len; arburst = burst; arsize = 3'd3; arid = id; arvalid = 1'b1;
    for (int c = 0; !arready && c < 20; c++) tick();
    chk("ar_ready", arready, 1);
    tick();
    arvalid = 1'b0;
    chk("r_first_latency", rvalid, 1);
    chk("ar_busy", arready, 0);
    for (int b = 0; b <= int'(len) && b < 4; b++) begin
      for (int c = 0; !rvalid && c < 20; c++) tick();
      if (b == stall_beat) begin
        rready = 1'b0;
        for (int c = 0; c < stall_n; c++) begin
          tick();
          chk("r_stall_valid", rvalid, 1);
          chk("r_stall_data", rdata, stall_data);
          chk("r_stall_last", rlast, stall_last);
        end
        rready = 1'b1;
      end
      rd_data[b] = rdata; rd_resp[b] = rresp; rd_last[b] = rlast;
      chk("r_id", rid, id);
      tick();
    end
    chk("ar_ready_after", arready, 1);
    chk("r_idle", rvalid, 0);
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int nbeats, input int bstall,
                             output logic [1:0] resp);
    awaddr = addr; awlen = len; awburst = burst; awsize = 3'd3; awid = 4'hA; awvalid = 1'b1;
    for (int c = 0; !awready && c < 20; c++) tick();
    chk("aw_ready", awready, 1);
    tick();
    awvalid = 1'b0;
    chk("w_ready_latency", wready, 1);
    chk("aw_busy", awready, 0);
    for (int b = 0; b < nbeats && b < 4; b++) begin
      wvalid = 1'b1; wdata = wr_data[b]; wstrb = wr_strb[b]; wlast = (b == nbeats - 1);
      for (int c = 0; !wready && c < 20; c++) tick();
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("b_latency", bvalid, 1);
    if (bstall > 0) begin
      bready = 1'b0;
      for (int c = 0; c < bstall; c++) begin
        tick();
        chk("b_hold_valid", bvalid, 1);
        chk("b_hold_awready", awready, 0);
      end
      bready = 1'b1;
    end
    for (int c = 0; !bvalid && c < 20; c++) tick();
    resp = bresp;
    chk("b_id", bid, 4'hA);
    tick();
    chk("aw_ready_after", awready, 1);
  endtask

  task automatic add(input bit wr, input logic [31:0] addr, input logic [1:0] burst,
                     input logic [63:0] data, input logic [7:0] strb,
                     input logic [63:0] exp_data, input logic [1:0] exp_resp, input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.burst = burst; v.data = data; v.strb = strb;
    v.exp_data = exp_data; v.exp_resp = exp_resp; v.name = name;
    vt.push_back(v);
  endtask

  logic [1:0]  resp;
  logic [63:0] burst_words [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    add(1, 32'h8000_0000, 2'b01, 64'h1122_3344_5566_7788, 8'hFF, '0, 2'b00, "w_word0");
    add(0, 32'h8000_0000, 2'b01, '0, '0, 64'h1122_3344_5566_7788, 2'b00, "r_word0");
    add(1, 32'h8000_0008, 2'b01, 64'h0, 8'hFF, '0, 2'b00, "w_zero8");
    add(1, 32'h8000_0008, 2'b01, 64'hAABB_CCDD_0000_0000, 8'hF0, '0, 2'b00, "w_strb_hi");
    add(0, 32'h8000_0008, 2'b01, '0, '0, 64'hAABB_CCDD_0000_0000, 2'b00, "r_strb_hi");
    add(1, 32'h8000_0008, 2'b01, 64'h0123_4567_89AB_CDEF, 8'h0F, '0, 2'b00, "w_strb_lo");
    add(0, 32'h8000_0008, 2'b01, '0, '0, 64'hAABB_CCDD_89AB_CDEF, 2'b00, "r_strb_lo");
    add(1, 32'h8000_1000, 2'b01, 64'hCAFE_BABE_00C0_FFEE, 8'hFF, '0, 2'b00, "w_alias");
    add(1, 32'h0000_1000, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, '0, 2'b10, "w_oob_low");
    add(0, 32'h0000_1000, 2'b01, '0, '0, 64'h0, 2'b10, "r_oob_low");
    add(0, 32'h8000_1000, 2'b01, '0, '0, 64'hCAFE_BABE_00C0_FFEE, 2'b00, "r_alias");
    add(1, 32'h8000_7FF8, 2'b01, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, '0, 2'b00, "w_top");
    add(0, 32'h8000_7FF8, 2'b01, '0, '0, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, "r_top");
    add(1, 32'h8000_8000, 2'b01, 64'h1234, 8'hFF, '0, 2'b10, "w_oob_high");
    add(0, 32'h8000_8000, 2'b01, '0, '0, 64'h0, 2'b10, "r_oob_high");
    add(0, 32'h7FFF_FFF8, 2'b01, '0, '0, 64'h0, 2'b10, "r_below");
    add(1, 32'h8000_0020, 2'b01, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, '0, 2'b00, "w_wrap_base");
    add(1, 32'h8000_0020, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, '0, 2'b10, "w_wrap");
    add(1, 32'h8000_0020, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, '0, 2'b10, "w_rsvd");
    add(0, 32'h8000_0020, 2'b10, '0, '0, 64'h0, 2'b10, "r_wrap");
    add(0, 32'h8000_0020, 2'b01, '0, '0, 64'h0F0F_0F0F_0F0F_0F0F, 2'b00, "r_after_wrap");

    // reset state
    tick(); tick();
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rid", rid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_bid", bid, 0);
    rst = 1'b1;
    tick();
    chk("rel_arready", arready, 1);
    chk("rel_awready", awready, 1);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].wr) begin
        wr_data[0] = vt[i].data; wr_strb[0] = vt[i].strb;
        write_burst(vt[i].addr, 8'd0, vt[i].burst, 1, 0, resp);
        chk({vt[i].name, "_bresp"}, resp, vt[i].exp_resp);
      end else begin
        read_burst(vt[i].addr, 8'd0, vt[i].burst, 4'h5, -1, 0, '0, 1'b0);
        chk({vt[i].name, "_rdata"}, rd_data[0], vt[i].exp_data);
        chk({vt[i].name, "_rresp"}, rd_resp[0], vt[i].exp_resp);
        chk({vt[i].name, "_rlast"}, rd_last[0], 1);
      end
    end

    // INCR burst write then read-back with a 5-cycle rready stall on beat 1
    burst_words[0] = 64'h1000_0000_0000_0001;
    burst_words[1] = 64'h2000_0000_0000_0002;
    burst_words[2] = 64'h3000_0000_0000_0003;
    burst_words[3] = 64'h4000_0000_0000_0004;
    for (int b = 0; b < 4; b++) begin wr_data[b] = burst_words[b]; wr_strb[b] = 8'hFF; end
    write_burst(32'h8000_0100, 8'd3, 2'b01, 4, 0, resp);
    chk("incr_w_bresp", resp, 2'b00);
    read_burst(32'h8000_0100, 8'd3, 2'b01, 4'h7, 1, 5, burst_words[1], 1'b0);
    for (int b = 0; b < 4; b++) begin
      chk("incr_r_data", rd_data[b], burst_words[b]);
      chk("incr_r_resp", rd_resp[b], 2'b00);
      chk("incr_r_last", rd_last[b], (b == 3));
    end

    // FIXED read burst stays on one word
    read_burst(32'h8000_0108, 8'd2, 2'b00, 4'h2, -1, 0, '0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      chk("fixed_r_data", rd_data[b], burst_words[1]);
      chk("fixed_r_last", rd_last[b], (b == 2));
    end

    // beat-count mismatches
    write_burst(32'h8000_0200, 8'd3, 2'b01, 2, 0, resp);
    chk("early_wlast_bresp", resp, 2'b10);
    write_burst(32'h8000_0200, 8'd0, 2'b01, 2, 0, resp);
    chk("late_wlast_bresp", resp, 2'b10);

    // B-channel backpressure
    wr_data[0] = 64'h5A5A_5A5A_A5A5_A5A5; wr_strb[0] = 8'hFF;
    write_burst(32'h8000_0300, 8'd0, 2'b01, 1, 4, resp);
    chk("bstall_bresp", resp, 2'b00);
    read_burst(32'h8000_0300, 8'd0, 2'b01, 4'h1, -1, 0, '0, 1'b0);
    chk("bstall_readback", rd_data[0], 64'h5A5A_5A5A_A5A5_A5A5);

    // reset in the middle of a 4-beat read
    araddr = 32'h8000_0100; arlen = 8'd3; arburst = 2'b01; arid = 4'h3; arvalid = 1'b1;
    for (int c = 0; !arready && c < 20; c++) tick();
    tick();
    arvalid = 1'b0;
    chk("mid_beat0", rdata, burst_words[0]);
    tick();
    chk("mid_beat1", rdata, burst_words[1]);
    rst = 1'b0;
    #1;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_arready", arready, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("mid_rel_arready", arready, 1);
    read_burst(32'h8000_0100, 8'd3, 2'b01, 4'h4, -1, 0, '0, 1'b0);
    for (int b = 0; b < 4; b++) chk("post_rst_data", rd_data[b], burst_words[b]);
    read_burst(32'h8000_0000, 8'd0, 2'b01, 4'h4, -1, 0, '0, 1'b0);
    chk("post_rst_word0", rd_data[0], 64'h1122_3344_5566_7788);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
